// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request, response and memory-side signals of the two-port data memory controller.
interface dmem_ctrl_if;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][2:0]  req_ctrl;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             mem_we;
    logic [31:0]      mem_a;
    logic [31:0]      mem_wd;
    logic [2:0]       mem_ctrl;
    logic [31:0]      mem_rd;
    modport slave (
        input  req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd, mem_ctrl
    );
    modport master (
        output req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd, mem_ctrl
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: two-port arbiter with sub-word load extension and read-modify-write stores.
// Define DMEM_CTRL_FIXED_PRIO_EN to give port 0 fixed priority instead of round-robin.
module dmem_ctrl #(
    parameter int MEM_WORDS = 64
) (
    input logic        clk,
    input logic        reset_n,
    dmem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;
    state_t      state, state_nx;
    logic        we_q, gnt_q, err_q, gnt, acc_err, sub, word_wr;
    logic [2:0]  ctrl_q;
    logic [4:0]  sh;
    logic [31:0] addr_q, wdata_q, rdata_q, merge_q, lane, load_val, mask, merged;
    // Lane shift: byte lanes on addr[1:0], half lanes on addr[1]
    assign sh       = ctrl_q[1:0] == 2'b00 ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
    assign sub      = !ctrl_q[1];
    assign acc_err  = (ctrl_q[1:0] == 2'b01 && addr_q[0]) || (ctrl_q[1] && addr_q[1:0] != 2'b00) ||
                      {2'b00, addr_q[31:2]} >= 32'(MEM_WORDS);
    assign word_wr  = we_q && !acc_err && !sub;
    assign lane     = bus.mem_rd >> sh;
    assign load_val = ctrl_q[1] ? bus.mem_rd
                    : ctrl_q[0] ? {{16{lane[15] & ~ctrl_q[2]}}, lane[15:0]}
                    : {{24{lane[7] & ~ctrl_q[2]}}, lane[7:0]};
    assign mask     = (ctrl_q[0] ? 32'h0000_ffff : 32'h0000_00ff) << sh;
    assign merged   = (merge_q & ~mask) | ((wdata_q << sh) & mask);
`ifdef DMEM_CTRL_FIXED_PRIO_EN
    assign gnt = !bus.req_valid[0];
`else
    logic last;
    // On contention the port that did not win last time is served
    assign gnt = &bus.req_valid ? !last : bus.req_valid[1];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last <= 1'b1;
        else if (state == IDLE && |bus.req_valid) last <= gnt;
    end
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            ctrl_q  <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            merge_q <= 32'h0;
        end else begin
            state <= state_nx;
            if (state == IDLE && |bus.req_valid) begin
                gnt_q   <= gnt;
                we_q    <= bus.req_we[gnt];
                ctrl_q  <= bus.req_ctrl[gnt];
                addr_q  <= bus.req_addr[gnt];
                wdata_q <= bus.req_wdata[gnt];
            end
            if (state == ACCESS) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || we_q) ? 32'h0 : load_val;
                merge_q <= bus.mem_rd;
            end
        end
    end
    always_comb begin
        state_nx      = state;
        bus.req_ready = 2'b00;
        bus.mem_we    = 1'b0;
        bus.mem_a     = 32'h0;
        bus.mem_wd    = 32'h0;
        case (state)
            IDLE: begin
                if (|bus.req_valid) begin
                    bus.req_ready[gnt] = 1'b1;
                    state_nx           = ACCESS;
                end
            end
            ACCESS: begin
                bus.mem_a  = {addr_q[31:2], 2'b00};
                bus.mem_we = word_wr;
                bus.mem_wd = word_wr ? wdata_q : 32'h0;
                state_nx   = (we_q && !acc_err && sub) ? MERGE : RESP;
            end
            MERGE: begin
                bus.mem_a  = {addr_q[31:2], 2'b00};
                bus.mem_we = 1'b1;
                bus.mem_wd = merged;
                state_nx   = RESP;
            end
            default: state_nx = IDLE;
        endcase
    end
    assign bus.rsp_valid = state == RESP ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_rdata = state == RESP ? rdata_q : 32'h0;
    assign bus.rsp_err   = state == RESP && err_q;
    assign bus.mem_ctrl  = 3'b010;
endmodule
